memory_accessing: RTL and testbench

// - MIPS pipeline MEM stage. Sits directly downstream of the EX stage: latches its outputs in the EX/MEM register,

---
 rtl/mips_pkg.sv | 34 +++
 rtl/data_memory.sv | 25 ++
 rtl/memory_accessing.sv | 103 ++++++++++
 tb/tb_memory_accessing.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: widths, EX/MEM and MEM/WB register layouts, bubble constants.
package mips_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef struct packed {
      logic                  mem_to_reg;
      logic                  reg_write;
      logic                  mem_write;
      logic                  mem_read;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     write_data;
      logic [REG_ADDR_W-1:0] rd;
   } ex_mem_t;

   // load_err marks a faulting access whose load data must read back as zero
   typedef struct packed {
      logic                  mem_to_reg;
      logic                  reg_write;
      logic                  load_err;
      logic [DATA_W-1:0]     alu_result;
      logic [REG_ADDR_W-1:0] rd;
   } mem_wb_t;

   localparam ex_mem_t ZERO_EX_MEM = '0;
   localparam mem_wb_t ZERO_MEM_WB = '0;

   function automatic logic addr_fault(input logic [DATA_W-1:0] addr,
                                       input int unsigned       depth_words);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[DATA_W-1:2]} >= depth_words);
   endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write, synchronous write-first read.
module data_memory
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [DATA_W-1:0]              wdata,
   output logic [DATA_W-1:0]              rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/memory_accessing.sv
// MIPS MEM stage: EX/MEM register, data-memory access with address checking,
// MEM/WB register and write-back data select.
module memory_accessing
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stallInput,
   input  logic                  flushInput,
   input  logic                  memToRegInput,
   input  logic                  regWriteInput,
   input  logic                  memWriteInput,
   input  logic                  memReadInput,
   input  logic [DATA_W-1:0]     aluResultInput,
   input  logic [DATA_W-1:0]     memWriteDataInput,
   input  logic [REG_ADDR_W-1:0] regWriteRegisterInput,
   output logic [DATA_W-1:0]     aluResultMemOutput,
   output logic [REG_ADDR_W-1:0] regWriteRegisterMemOutput,
   output logic                  regWriteMemOutput,
   output logic                  memReadMemOutput,
   output logic [DATA_W-1:0]     regWriteDataWbOutput,
   output logic [REG_ADDR_W-1:0] regWriteRegisterWbOutput,
   output logic                  regWriteWbOutput,
   output logic                  addressErrorOutput
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   ex_mem_t           ex_mem_d, ex_mem_q;
   mem_wb_t           mem_wb_d, mem_wb_q;
   logic              err, advance, mem_we, addr_err_q;
   logic [DATA_W-1:0] rdata, load_data;

   assign advance = ~stallInput & ~flushInput;
   assign err     = (ex_mem_q.mem_read | ex_mem_q.mem_write)
                    & addr_fault(ex_mem_q.alu_result, DEPTH_WORDS);
   // A held store only writes on the edge it actually leaves EX/MEM
   assign mem_we  = ex_mem_q.mem_write & ~err & advance;

   always_comb begin
      ex_mem_d = ex_mem_q;
      if (flushInput) begin
         ex_mem_d = ZERO_EX_MEM;
      end else if (!stallInput) begin
         ex_mem_d.mem_to_reg = memToRegInput;
         ex_mem_d.reg_write  = regWriteInput;
         ex_mem_d.mem_write  = memWriteInput;
         ex_mem_d.mem_read   = memReadInput;
         ex_mem_d.alu_result = aluResultInput;
         ex_mem_d.write_data = memWriteDataInput;
         ex_mem_d.rd         = regWriteRegisterInput;
      end
   end

   always_comb begin
      mem_wb_d = ZERO_MEM_WB;
      if (advance) begin
         mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
         mem_wb_d.reg_write  = ex_mem_q.reg_write;
         mem_wb_d.load_err   = err;
         mem_wb_d.alu_result = ex_mem_q.alu_result;
         mem_wb_d.rd         = ex_mem_q.rd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_mem_q   <= ZERO_EX_MEM;
         mem_wb_q   <= ZERO_MEM_WB;
         addr_err_q <= 1'b0;
      end else begin
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
         if (advance && err) begin
            addr_err_q <= 1'b1;
         end
      end
   end

   data_memory #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_data_memory (
      .clk  (clk),
      .we   (mem_we),
      .addr (ex_mem_q.alu_result[AW+1:2]),
      .wdata(ex_mem_q.write_data),
      .rdata(rdata)
   );

   assign load_data = mem_wb_q.load_err ? '0 : rdata;

   assign aluResultMemOutput        = ex_mem_q.alu_result;
   assign regWriteRegisterMemOutput = ex_mem_q.rd;
   assign regWriteMemOutput         = ex_mem_q.reg_write;
   assign memReadMemOutput          = ex_mem_q.mem_read;
   assign regWriteDataWbOutput      = mem_wb_q.mem_to_reg ? load_data : mem_wb_q.alu_result;
   assign regWriteRegisterWbOutput  = mem_wb_q.rd;
   assign regWriteWbOutput          = mem_wb_q.reg_write;
   assign addressErrorOutput        = addr_err_q;

endmodule

// File: tb/tb_memory_accessing.sv
// Bench for memory_accessing: write-back results checked against a scoreboard fed at issue time.
module tb_memory_accessing;

   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stallInput = 1'b0, flushInput = 1'b0;
   logic        memToRegInput = 1'b0, regWriteInput = 1'b0;
   logic        memWriteInput = 1'b0, memReadInput = 1'b0;
   logic [31:0] aluResultInput = '0, memWriteDataInput = '0;
   logic [4:0]  regWriteRegisterInput = '0;
   logic [31:0] aluResultMemOutput, regWriteDataWbOutput;
   logic [4:0]  regWriteRegisterMemOutput, regWriteRegisterWbOutput;
   logic        regWriteMemOutput, memReadMemOutput, regWriteWbOutput, addressErrorOutput;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t     sb[$];
   logic [31:0] model[int];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   memory_accessing #(
      .DEPTH_WORDS(DEPTH)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .stallInput               (stallInput),
      .flushInput               (flushInput),
      .memToRegInput            (memToRegInput),
      .regWriteInput            (regWriteInput),
      .memWriteInput            (memWriteInput),
      .memReadInput             (memReadInput),
      .aluResultInput           (aluResultInput),
      .memWriteDataInput        (memWriteDataInput),
      .regWriteRegisterInput    (regWriteRegisterInput),
      .aluResultMemOutput       (aluResultMemOutput),
      .regWriteRegisterMemOutput(regWriteRegisterMemOutput),
      .regWriteMemOutput        (regWriteMemOutput),
      .memReadMemOutput         (memReadMemOutput),
      .regWriteDataWbOutput     (regWriteDataWbOutput),
      .regWriteRegisterWbOutput (regWriteRegisterWbOutput),
      .regWriteWbOutput         (regWriteWbOutput),
      .addressErrorOutput       (addressErrorOutput)
   );

   // One clock; any write-back the DUT produces is matched against the scoreboard head
   task automatic cycle();
      wb_exp_t e;
      @(posedge clk);
      #1;
      if (regWriteWbOutput === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write-back",
                     regWriteRegisterWbOutput, regWriteDataWbOutput);
         end else begin
            e = sb.pop_front();
            if ({regWriteRegisterWbOutput, regWriteDataWbOutput} !== {e.rd, e.data}) begin
               errors++;
               $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                        regWriteRegisterWbOutput, regWriteDataWbOutput, e.rd, e.data);
            end
         end
      end
   endtask

   task automatic drive(input logic mtr, input logic rw, input logic mw, input logic mr,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
      memToRegInput         = mtr;
      regWriteInput         = rw;
      memWriteInput         = mw;
      memReadInput          = mr;
      aluResultInput        = addr;
      memWriteDataInput     = wdata;
      regWriteRegisterInput = rd;
   endtask

   // commit=0: instruction will be cancelled, so neither memory model nor scoreboard change
   task automatic issue(input logic mtr, input logic rw, input logic mw, input logic mr,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input bit commit = 1'b1);
      logic    fault;
      int      idx;
      wb_exp_t e;
      fault = (mr | mw) && ((addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH));
      idx   = int'(addr >> 2);
      drive(mtr, rw, mw, mr, addr, wdata, rd);
      if (commit) begin
         if (mw && !fault) model[idx] = wdata;
         if (rw) begin
            e.rd = rd;
            if (fault) e.data = 32'h0;
            else if (mtr) e.data = model.exists(idx) ? model[idx] : 32'h0;
            else e.data = addr;
            sb.push_back(e);
         end
      end
      cycle();
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      cycle();
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      #1;
      checks++;
      if ({aluResultMemOutput, regWriteRegisterMemOutput, regWriteMemOutput, memReadMemOutput}
          !== '0) begin
         errors++;
         $display("FAIL reset_mem: got alu=%h rd=%0d rw=%b mr=%b, required all 0",
                  aluResultMemOutput, regWriteRegisterMemOutput, regWriteMemOutput,
                  memReadMemOutput);
      end
      checks++;
      if ({regWriteDataWbOutput, regWriteRegisterWbOutput, regWriteWbOutput} !== '0) begin
         errors++;
         $display("FAIL reset_wb: got data=%h rd=%0d rw=%b, required all 0",
                  regWriteDataWbOutput, regWriteRegisterWbOutput, regWriteWbOutput);
      end
      checks++;
      if (addressErrorOutput !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %b, required 0", addressErrorOutput);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_alu();
      issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
      checks++;
      if ({aluResultMemOutput, regWriteMemOutput, regWriteRegisterMemOutput}
          !== {32'h0000_1234, 1'b1, 5'd5}) begin
         errors++;
         $display("FAIL alu_mem: got alu=%h rw=%b rd=%0d, required 1234/1/5",
                  aluResultMemOutput, regWriteMemOutput, regWriteRegisterMemOutput);
      end
      checks++;
      if (regWriteWbOutput !== 1'b0) begin
         errors++;
         $display("FAIL alu_wb_early: got regWriteWb=%b after 1 edge, required 0",
                  regWriteWbOutput);
      end
      nop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL alu_latency: got %0d results pending after 2 edges, required 0",
                  sb.size());
         sb.delete();
      end
   endtask

   task automatic test_store_load();
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0000_1111, 5'd0);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0000_3030, 5'd0);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 32'h0000_7777, 5'd0);
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd8);
      checks++;
      if (memReadMemOutput !== 1'b1) begin
         errors++;
         $display("FAIL lw_memread: got %b, required 1", memReadMemOutput);
      end
      for (int c = 0; c < 4 && sb.size() != 0; c++) nop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL store_load_drain: got %0d pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_misaligned();
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h13, 32'h1, 5'd0);
      checks++;
      if (addressErrorOutput !== 1'b0) begin
         errors++;
         $display("FAIL err_early: got %b while entry still in EX/MEM, required 0",
                  addressErrorOutput);
      end
      nop();
      checks++;
      if (addressErrorOutput !== 1'b1) begin
         errors++;
         $display("FAIL err_misaligned: got %b, required 1", addressErrorOutput);
      end
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd8);
      for (int c = 0; c < 4 && sb.size() != 0; c++) nop();
      checks++;
      if (sb.size() != 0 || addressErrorOutput !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got pending=%0d err=%b, required 0 and 1",
                  sb.size(), addressErrorOutput);
         sb.delete();
      end
   endtask

   task automatic test_async_reset();
      issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_4444, 32'h0, 5'd4);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0000_0BAD, 5'd0, 1'b0);
      #3;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      #1;
      checks++;
      if ({aluResultMemOutput, regWriteRegisterMemOutput, regWriteMemOutput, memReadMemOutput,
           regWriteDataWbOutput, regWriteRegisterWbOutput, regWriteWbOutput} !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs: got alu=%h wbdata=%h wbrw=%b, required all 0",
                  aluResultMemOutput, regWriteDataWbOutput, regWriteWbOutput);
      end
      checks++;
      if (addressErrorOutput !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_err: got %b, required 0", addressErrorOutput);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 5'd3);
      for (int c = 0; c < 4 && sb.size() != 0; c++) nop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL async_reset_resume: got %0d pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_out_of_range();
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'(4 * DEPTH), 32'h0, 5'd9);
      nop();
      checks++;
      if (addressErrorOutput !== 1'b1) begin
         errors++;
         $display("FAIL err_range: got %b, required 1", addressErrorOutput);
      end
      for (int c = 0; c < 4 && sb.size() != 0; c++) nop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL range_drain: got %0d pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_stall();
      issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_AAAA, 32'h0, 5'd11);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'hA5A5_A5A5, 5'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      stallInput = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cycle();
         checks++;
         if (regWriteWbOutput !== 1'b0 || aluResultMemOutput !== 32'h20) begin
            errors++;
            $display("FAIL stall_hold: got wbrw=%b memalu=%h, required 0 and 00000020",
                     regWriteWbOutput, aluResultMemOutput);
         end
      end
      stallInput = 1'b0;
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd10);
      // a stalled register-writing op must not repeat into write-back
      issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 5'd12);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      stallInput = 1'b1;
      repeat (2) cycle();
      stallInput = 1'b0;
      for (int c = 0; c < 4 && sb.size() != 0; c++) nop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL stall_drain: got %0d pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_flush();
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0000_0005, 5'd0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      stallInput = 1'b1;
      flushInput = 1'b1;
      cycle();
      checks++;
      if (aluResultMemOutput !== 32'h0 || regWriteWbOutput !== 1'b0) begin
         errors++;
         $display("FAIL flush_bubble: got memalu=%h wbrw=%b, required 0 and 0",
                  aluResultMemOutput, regWriteWbOutput);
      end
      stallInput = 1'b0;
      issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'h0, 5'd14, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      cycle();
      checks++;
      if (regWriteMemOutput !== 1'b0) begin
         errors++;
         $display("FAIL flush_ctrl: got regWriteMem=%b, required 0", regWriteMemOutput);
      end
      flushInput = 1'b0;
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h24, 32'h0, 5'd13);
      for (int c = 0; c < 4 && sb.size() != 0; c++) nop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL flush_drain: got %0d pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h140, 32'hCAFE_F00D, 5'd0);
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h140, 32'h0, 5'd15);
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), $urandom, 5'd0);
      end
      for (int i = 0; i < 24; i++) begin
         a = 32'h100 + 32'(4 * $urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0: issue(1'b0, 1'b1, 1'b0, 1'b0, $urandom, 32'h0, 5'($urandom_range(1, 31)));
            1: issue(1'b1, 1'b1, 1'b0, 1'b1, a, 32'h0, 5'($urandom_range(1, 31)));
            default: issue(1'b0, 1'b0, 1'b1, 1'b0, a, $urandom, 5'd0);
         endcase
      end
      for (int c = 0; c < 4 && sb.size() != 0; c++) nop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store_load();
      test_misaligned();
      test_async_reset();
      test_out_of_range();
      test_stall();
      test_flush();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish within 200000 time units, required completion");
      $fatal(1, "timeout");
   end

endmodule
